noc_output_port: RTL and testbench
==================================

# noc_output_port

Output-port controller for the on-chip network router, one instance per output. It collects head flits from the N input buffers and presents them as a request vector to the port's round-robin arbiter. It consumes the arbiter's one-hot grant and holds the winning input until that packet's tail flit has passed (wormhole lock). Forwarded flits go to the downstream link through a registered output, under credit-based flow control.

## Interface
- N, 8: number of input ports (requesters).
- W, 64: flit payload width in bits.
- CREDITS, 4: downstream buffer depth; initial and maximum credit count.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  N  input i has a flit at its buffer head.
- in_data  in  N*W  head flit payloads; input i occupies bits [i*W +: W].
- in_head  in  N  head-flit marker per input.
- in_tail  in  N  tail-flit marker per input; a single-flit packet has head=tail=1.
- in_ready  out  N  flit on input i is consumed this cycle (pop strobe).
- arb_req  out  N  request vector driven to the round-robin arbiter.
- arb_grant  in  N  combinational one-hot grant returned by the arbiter in the same cycle.
- out_valid  out  1  flit valid on the downstream link; registered.
- out_data  out  W  forwarded payload; registered.
- out_head, out_tail  out  1  forwarded markers; registered.
- credit_ret  in  1  downstream freed one buffer slot; at most one per cycle.
- credit_count  out  $clog2(CREDITS+1)  current credits; registered.

## Operation
- State machine: IDLE (no owner) and LOCKED (owner = owner_idx, $clog2(N) bits).
- can_send = (credit_count != 0).
- IDLE:
  - arb_req = in_valid & in_head, or all zeros if !can_send.
  - sel = arb_grant & arb_req. If sel is nonzero, g = lowest set index of sel.
  - in_ready[g]=1 and the flit from input g is forwarded.
  - If in_tail[g]=0: go to LOCKED with owner_idx=g. If in_tail[g]=1: stay in IDLE.
  - If sel is zero: no transfer.
- LOCKED:
  - arb_req = 0, so the arbiter pointer does not advance.
  - in_ready[owner_idx] = in_valid[owner_idx] & can_send.
  - A head flit arriving while LOCKED is forwarded as data; it is a protocol error (see Configuration).
  - When a tail flit transfers: go to IDLE.
  - Input stalls (in_valid low) hold LOCKED indefinitely.
- All in_ready bits other than the selected input are 0; at most one in_ready bit is high per cycle.
- A grant to a non-requesting input is ignored.
- Credits:
  - Send only: decrement. credit_ret only: increment. Send and credit_ret in the same cycle: unchanged.
  - The counter saturates at CREDITS. It never underflows, because a send requires can_send.

## Timing
- in_ready and arb_req are combinational from state, credit_count, in_valid/in_head and arb_grant.
- There is no combinational path from credit_ret.
- Latency: a flit accepted in cycle t appears on out_* in cycle t+1 with out_valid=1 for exactly one cycle. Throughput is one flit per cycle.
- The credit decrement for a flit sent in cycle t is visible in credit_count at t+1.
- A credit_ret in cycle t enables a send at t+1 at the earliest.
- Reset values: state=IDLE, owner_idx=0, out_valid=0, out_data=0, out_head=0, out_tail=0, credit_count=CREDITS, err=0.
- Reset mid-packet abandons the lock and restores full credits. The downstream buffer is reset by the same rst.
- out_data holds its last value when out_valid=0.

## Configuration
- NOC_OUTPORT_CHECK_EN defined:
  - Adds output err (1 bit, registered, sticky until rst).
  - err is set by any of the following:
    - popcount(arb_grant)>1 while in IDLE;
    - credit_ret while credit_count==CREDITS with no simultaneous send;
    - a head flit transferred in LOCKED;
    - a non-head flit granted in IDLE (cannot occur given arb_req masking; checked on in_head[g]).
  - Data behaviour is identical with and without the macro.
- Undefined: the err port and all checking logic are absent.

## Test plan
- Single-flit packets: in_valid=8'h05, in_head=in_tail=8'h05, arb_grant=8'h01 -> in_ready=8'h01; next cycle out_valid=1, out_data=input 0 payload, credit_count=3.
- 3-flit packet from input 2 with input 5 also requesting:
  - grant input 2 -> LOCKED;
  - arb_req=0 for the two following cycles;
  - in_ready=8'h04 three times;
  - IDLE after the tail, then arb_req=8'h20.
- Credit exhaustion (CREDITS=4, no credit_ret):
  - four flits forwarded, then credit_count=0, in_ready=0 and arb_req=0;
  - credit_ret pulse -> one more flit forwarded the following cycle.
- Simultaneous send and credit_ret with credit_count=2 -> credit_count stays 2, and the flit is forwarded.
- rst asserted mid-packet in LOCKED with credit_count=1 -> next cycle IDLE, credit_count=4, out_valid=0.
- With NOC_OUTPORT_CHECK_EN: arb_grant=8'h03 in IDLE, or credit_ret at full credits -> err=1 and stays 1 until rst.

Source files
------------

// File: rtl/noc_output_port_if.sv
// Handshake bundle between the input buffers, the round-robin arbiter, the
// downstream link and one noc_output_port instance.
interface noc_output_port_if #(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = 64,
  parameter int unsigned CREDITS = 4
);
  localparam int unsigned CntW = $clog2(CREDITS + 1);

  logic [N-1:0]    in_valid;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_head;
  logic [N-1:0]    in_tail;
  logic [N-1:0]    in_ready;
  logic [N-1:0]    arb_req;
  logic [N-1:0]    arb_grant;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            out_head;
  logic            out_tail;
  logic            credit_ret;
  logic [CntW-1:0] credit_count;

  // The output-port controller.
  modport slave (
    input  in_valid, in_data, in_head, in_tail, arb_grant, credit_ret,
    output in_ready, arb_req, out_valid, out_data, out_head, out_tail, credit_count
  );

  // The surrounding router: input buffers, arbiter and downstream link.
  modport master (
    output in_valid, in_data, in_head, in_tail, arb_grant, credit_ret,
    input  in_ready, arb_req, out_valid, out_data, out_head, out_tail, credit_count
  );
endinterface

// File: rtl/noc_output_port.sv
// Router output port: wormhole-locked flit forwarding with credit flow control.
// Optional protocol checker with sticky err output when NOC_OUTPORT_CHECK_EN is defined.
module noc_output_port #(
  parameter int unsigned N       = 8,
  parameter int unsigned W       = 64,
  parameter int unsigned CREDITS = 4
) (
  input  logic             clk,
  input  logic             rst,
`ifdef NOC_OUTPORT_CHECK_EN
  output logic             err,
`endif
  noc_output_port_if.slave bus
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned CntW = $clog2(CREDITS + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q;
  logic [IdxW-1:0] owner_q;
  logic [CntW-1:0] credit_q, credit_d;
  logic            out_valid_q, out_head_q, out_tail_q;
  logic [W-1:0]    out_data_q;

  logic            can_send;
  logic            fire;
  logic [IdxW-1:0] g;
  logic [N-1:0]    arb_req, sel, in_ready;
  logic [W-1:0]    fwd_data;
  logic            fwd_head, fwd_tail;

  always_comb begin
    can_send = (credit_q != '0);
    arb_req  = '0;
    sel      = '0;
    fire     = 1'b0;
    g        = '0;
    if (state_q == StIdle) begin
      if (can_send) arb_req = bus.in_valid & bus.in_head;
      // Grants outside the request vector are dropped here.
      sel = bus.arb_grant & arb_req;
      for (int i = 0; i < int'(N); i++) begin
        if (sel[i] && !fire) begin
          fire = 1'b1;
          g    = IdxW'(i);
        end
      end
    end else begin
      g    = owner_q;
      fire = bus.in_valid[owner_q] & can_send;
    end
    in_ready = fire ? (N'(1) << g) : '0;
    fwd_data = bus.in_data[g*W +: W];
    fwd_head = bus.in_head[g];
    fwd_tail = bus.in_tail[g];
  end

  always_comb begin
    credit_d = credit_q;
    unique case ({fire, bus.credit_ret})
      2'b10:   credit_d = credit_q - 1'b1;
      2'b01:   if (credit_q != CntW'(CREDITS)) credit_d = credit_q + 1'b1;
      default: credit_d = credit_q;
    endcase
  end

`ifdef NOC_OUTPORT_CHECK_EN
  logic err_set;
  always_comb begin
    err_set = 1'b0;
    if (state_q == StIdle && ((bus.arb_grant & (bus.arb_grant - 1'b1)) != '0)) err_set = 1'b1;
    if (bus.credit_ret && !fire && credit_q == CntW'(CREDITS)) err_set = 1'b1;
    if (fire && state_q == StLocked && fwd_head) err_set = 1'b1;
    if (fire && state_q == StIdle && !fwd_head) err_set = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_head_q  <= 1'b0;
      out_tail_q  <= 1'b0;
      credit_q    <= CntW'(CREDITS);
`ifdef NOC_OUTPORT_CHECK_EN
      err         <= 1'b0;
`endif
    end else begin
      out_valid_q <= fire;
      credit_q    <= credit_d;
      if (fire) begin
        out_data_q <= fwd_data;
        out_head_q <= fwd_head;
        out_tail_q <= fwd_tail;
        if (state_q == StIdle && !fwd_tail) begin
          state_q <= StLocked;
          owner_q <= g;
        end else if (state_q == StLocked && fwd_tail) begin
          state_q <= StIdle;
        end
      end
`ifdef NOC_OUTPORT_CHECK_EN
      if (err_set) err <= 1'b1;
`endif
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.arb_req      = arb_req;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_head     = out_head_q;
  assign bus.out_tail     = out_tail_q;
  assign bus.credit_count = credit_q;

endmodule

// File: tb/tb_noc_output_port.sv
// Directed self-checking bench for noc_output_port (N=8, W=64, CREDITS=4).
module tb_noc_output_port;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;
  logic [7:0] tag = 8'h00;
`ifdef NOC_OUTPORT_CHECK_EN
  logic err;
`endif

  always #5 clk = ~clk;

  noc_output_port_if #(.N(8), .W(64), .CREDITS(4)) bus ();

  noc_output_port #(.N(8), .W(64), .CREDITS(4)) dut (
    .clk (clk),
    .rst (rst),
`ifdef NOC_OUTPORT_CHECK_EN
    .err (err),
`endif
    .bus (bus)
  );

  function automatic logic [63:0] payload(input int i, input logic [7:0] t);
    logic [31:0] iv;
    iv = i;
    return {32'hC0DE_F00D, 16'h0000, t, iv[7:0]};
  endfunction

  // Applies inputs at the falling edge with a fresh payload tag.
  task automatic drive(input logic [7:0] v, input logic [7:0] h, input logic [7:0] t,
                       input logic [7:0] gr, input logic cr);
    @(negedge clk);
    tag            = tag + 8'd1;
    bus.in_valid   = v;
    bus.in_head    = h;
    bus.in_tail    = t;
    bus.arb_grant  = gr;
    bus.credit_ret = cr;
    for (int i = 0; i < 8; i++) bus.in_data[i*64 +: 64] = payload(i, tag);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = '0; bus.in_head = '0; bus.in_tail = '0;
    bus.arb_grant = '0; bus.credit_ret = 1'b0; bus.in_data = '0;
    tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 64'h0) $display("FAIL reset_out_data: got %h want 0", bus.out_data); else passed++;
    total++; if ({bus.out_head, bus.out_tail} !== 2'b00) $display("FAIL reset_markers: got %b want 00", {bus.out_head, bus.out_tail}); else passed++;
    total++; if (bus.credit_count !== 3'd4) $display("FAIL reset_credits: got %0d want 4", bus.credit_count); else passed++;
    total++; if (bus.in_ready !== 8'h00) $display("FAIL reset_in_ready: got %h want 00", bus.in_ready); else passed++;
  endtask

  task automatic test_single_flit();
    logic [7:0] t0;
    do_reset();
    drive(8'h05, 8'h05, 8'h05, 8'h01, 1'b0);
    t0 = tag;
    total++; if (bus.arb_req !== 8'h05) $display("FAIL single_arb_req: got %h want 05", bus.arb_req); else passed++;
    total++; if (bus.in_ready !== 8'h01) $display("FAIL single_in_ready: got %h want 01", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b1) $display("FAIL single_out_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== payload(0, t0)) $display("FAIL single_out_data: got %h want %h", bus.out_data, payload(0, t0)); else passed++;
    total++; if ({bus.out_head, bus.out_tail} !== 2'b11) $display("FAIL single_markers: got %b want 11", {bus.out_head, bus.out_tail}); else passed++;
    total++; if (bus.credit_count !== 3'd3) $display("FAIL single_credits: got %0d want 3", bus.credit_count); else passed++;
    // Grant to input 2 still in IDLE: single-flit packet left no lock.
    drive(8'h05, 8'h05, 8'h05, 8'h04, 1'b0);
    t0 = tag;
    total++; if (bus.in_ready !== 8'h04) $display("FAIL single2_in_ready: got %h want 04", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_data !== payload(2, t0)) $display("FAIL single2_out_data: got %h want %h", bus.out_data, payload(2, t0)); else passed++;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL single_one_cycle: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== payload(2, t0)) $display("FAIL single_hold: got %h want %h", bus.out_data, payload(2, t0)); else passed++;
    total++; if (bus.credit_count !== 3'd2) $display("FAIL single_credits2: got %0d want 2", bus.credit_count); else passed++;
  endtask

  task automatic test_wormhole();
    logic [7:0] t0;
    do_reset();
    drive(8'h24, 8'h24, 8'h00, 8'h04, 1'b0);
    total++; if (bus.arb_req !== 8'h24) $display("FAIL worm_req0: got %h want 24", bus.arb_req); else passed++;
    total++; if (bus.in_ready !== 8'h04) $display("FAIL worm_ready0: got %h want 04", bus.in_ready); else passed++;
    tick();
    total++; if ({bus.out_valid, bus.out_head, bus.out_tail} !== 3'b110) $display("FAIL worm_out0: got %b want 110", {bus.out_valid, bus.out_head, bus.out_tail}); else passed++;
    // Body flit; arbiter offering input 5 must be ignored while locked.
    drive(8'h24, 8'h20, 8'h00, 8'h20, 1'b0);
    t0 = tag;
    total++; if (bus.arb_req !== 8'h00) $display("FAIL worm_req1: got %h want 00", bus.arb_req); else passed++;
    total++; if (bus.in_ready !== 8'h04) $display("FAIL worm_ready1: got %h want 04", bus.in_ready); else passed++;
    tick();
    total++; if (bus.out_data !== payload(2, t0)) $display("FAIL worm_data1: got %h want %h", bus.out_data, payload(2, t0)); else passed++;
    drive(8'h20, 8'h20, 8'h00, 8'h20, 1'b0);
    total++; if (bus.in_ready !== 8'h00) $display("FAIL worm_stall_ready: got %h want 00", bus.in_ready); else passed++;
    total++; if (bus.arb_req !== 8'h00) $display("FAIL worm_stall_req: got %h want 00", bus.arb_req); else passed++;
    tick();
    drive(8'h24, 8'h20, 8'h04, 8'h00, 1'b0);
    total++; if (bus.arb_req !== 8'h00) $display("FAIL worm_req2: got %h want 00", bus.arb_req); else passed++;
    total++; if (bus.in_ready !== 8'h04) $display("FAIL worm_ready2: got %h want 04", bus.in_ready); else passed++;
    tick();
    total++; if ({bus.out_valid, bus.out_head, bus.out_tail} !== 3'b101) $display("FAIL worm_out2: got %b want 101", {bus.out_valid, bus.out_head, bus.out_tail}); else passed++;
    total++; if (bus.credit_count !== 3'd1) $display("FAIL worm_credits: got %0d want 1", bus.credit_count); else passed++;
    drive(8'h20, 8'h20, 8'h00, 8'h01, 1'b0);
    total++; if (bus.arb_req !== 8'h20) $display("FAIL worm_idle_req: got %h want 20", bus.arb_req); else passed++;
    total++; if (bus.in_ready !== 8'h00) $display("FAIL worm_bad_grant: got %h want 00", bus.in_ready); else passed++;
    tick();
  endtask

  task automatic test_credit_exhaust();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(8'h02, 8'h02, 8'h02, 8'h02, 1'b0);
      total++; if (bus.in_ready !== 8'h02) $display("FAIL exh_ready%0d: got %h want 02", k, bus.in_ready); else passed++;
      tick();
      total++; if (bus.credit_count !== 3'(3 - k)) $display("FAIL exh_credits%0d: got %0d want %0d", k, bus.credit_count, 3 - k); else passed++;
    end
    drive(8'h02, 8'h02, 8'h02, 8'h02, 1'b0);
    total++; if (bus.in_ready !== 8'h00) $display("FAIL exh_zero_ready: got %h want 00", bus.in_ready); else passed++;
    total++; if (bus.arb_req !== 8'h00) $display("FAIL exh_zero_req: got %h want 00", bus.arb_req); else passed++;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL exh_no_send: got %b want 0", bus.out_valid); else passed++;
    drive(8'h02, 8'h02, 8'h02, 8'h02, 1'b1);
    total++; if (bus.in_ready !== 8'h00) $display("FAIL exh_ret_comb: got %h want 00", bus.in_ready); else passed++;
    tick();
    total++; if (bus.credit_count !== 3'd1) $display("FAIL exh_ret_credit: got %0d want 1", bus.credit_count); else passed++;
    drive(8'h02, 8'h02, 8'h02, 8'h02, 1'b0);
    total++; if (bus.in_ready !== 8'h02) $display("FAIL exh_resume_ready: got %h want 02", bus.in_ready); else passed++;
    tick();
    total++; if ({bus.out_valid, bus.credit_count} !== {1'b1, 3'd0}) $display("FAIL exh_resume: got %b/%0d want 1/0", bus.out_valid, bus.credit_count); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] t0;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      drive(8'h08, 8'h08, 8'h08, 8'h08, 1'b0);
      tick();
    end
    total++; if (bus.credit_count !== 3'd2) $display("FAIL sim_pre: got %0d want 2", bus.credit_count); else passed++;
    drive(8'h08, 8'h08, 8'h08, 8'h08, 1'b1);
    t0 = tag;
    total++; if (bus.in_ready !== 8'h08) $display("FAIL sim_ready: got %h want 08", bus.in_ready); else passed++;
    tick();
    total++; if (bus.credit_count !== 3'd2) $display("FAIL sim_credits: got %0d want 2", bus.credit_count); else passed++;
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== payload(3, t0)) $display("FAIL sim_fwd: got %b/%h want 1/%h", bus.out_valid, bus.out_data, payload(3, t0)); else passed++;
    for (int k = 0; k < 3; k++) begin
      drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
      tick();
    end
    total++; if (bus.credit_count !== 3'd4) $display("FAIL sim_saturate: got %0d want 4", bus.credit_count); else passed++;
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    drive(8'h40, 8'h40, 8'h00, 8'h40, 1'b0);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(8'h40, 8'h00, 8'h00, 8'h00, 1'b0);
      tick();
    end
    total++; if (bus.credit_count !== 3'd1) $display("FAIL mid_pre_credits: got %0d want 1", bus.credit_count); else passed++;
    @(negedge clk);
    rst = 1'b1;
    tick();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.credit_count !== 3'd4) $display("FAIL mid_credits: got %0d want 4", bus.credit_count); else passed++;
    @(negedge clk);
    rst = 1'b0;
    drive(8'h41, 8'h01, 8'h01, 8'h00, 1'b0);
    total++; if (bus.arb_req !== 8'h01) $display("FAIL mid_idle_req: got %h want 01", bus.arb_req); else passed++;
    tick();
  endtask

`ifdef NOC_OUTPORT_CHECK_EN
  task automatic test_err();
    do_reset();
    total++; if (err !== 1'b0) $display("FAIL err_reset: got %b want 0", err); else passed++;
    drive(8'h03, 8'h03, 8'h03, 8'h03, 1'b0);
    tick();
    total++; if (err !== 1'b1) $display("FAIL err_multigrant: got %b want 1", err); else passed++;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    tick();
    total++; if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err); else passed++;
    do_reset();
    total++; if (err !== 1'b0) $display("FAIL err_cleared: got %b want 0", err); else passed++;
    drive(8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
    tick();
    total++; if (err !== 1'b1) $display("FAIL err_overcredit: got %b want 1", err); else passed++;
  endtask
`endif

  initial begin
    bus.in_valid = '0; bus.in_head = '0; bus.in_tail = '0;
    bus.arb_grant = '0; bus.credit_ret = 1'b0; bus.in_data = '0;
    test_reset();
    test_single_flit();
    test_wormhole();
    test_credit_exhaust();
    test_simultaneous();
    test_reset_mid_packet();
`ifdef NOC_OUTPORT_CHECK_EN
    test_err();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
